// File: rtl/credit_accumulator_if.sv
// Coin/vend/refund bus for credit_accumulator.
// Master drives coin/vend/cancel requests; slave returns credit, pulses, change, busy.
interface credit_accumulator_if #(
   parameter int COIN_W   = 4,
   parameter int CREDIT_W = 8
);
   logic                coin_valid;
   logic [COIN_W-1:0]   coin;
   logic                vend_req;
   logic [CREDIT_W-1:0] price;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                coin_accept;
   logic                coin_reject;
   logic                vend_ok;
   logic                vend_deny;
   logic                change_valid;
   logic [CREDIT_W-1:0] change;
   logic                busy;

   modport master (
      output coin_valid, coin, vend_req, price, cancel,
      input  credit, coin_accept, coin_reject, vend_ok, vend_deny,
      input  change_valid, change, busy
   );

   modport slave (
      input  coin_valid, coin, vend_req, price, cancel,
      output credit, coin_accept, coin_reject, vend_ok, vend_deny,
      output change_valid, change, busy
   );
endinterface

// File: rtl/credit_accumulator.sv
// Vending credit accumulator: accepts coins, vends against credit, refunds change.
// Ports: clk, rst (sync, active-high), bus (credit_accumulator_if.slave).
module credit_accumulator #(
   parameter int COIN_W          = 4,
   parameter int CREDIT_W        = 8,
   parameter int MAX_CREDIT      = 50,
   parameter int DISPENSE_CYCLES = 3,
   parameter int AUTO_CHANGE     = 1
) (
   input logic               clk,
   input logic               rst,
   credit_accumulator_if.slave bus
);
   localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPENSE_CYCLES - 1);
   localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W+1)'(MAX_CREDIT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      RETURN   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                acc_q, acc_d;
   logic                rej_q, rej_d;
   logic                ok_q, ok_d;
   logic                deny_q, deny_d;
   logic                cv_q, cv_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic [CREDIT_W:0]   sum;

   // One extra bit so an overflowing sum is seen as over the ceiling
   assign sum = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin);

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cnt_d    = cnt_q;
      acc_d    = 1'b0;
      rej_d    = 1'b0;
      ok_d     = 1'b0;
      deny_d   = 1'b0;
      cv_d     = 1'b0;
      change_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.cancel) begin
               rej_d  = bus.coin_valid;
               deny_d = bus.vend_req;
               if (credit_q != '0) begin
                  state_d  = RETURN;
                  cv_d     = 1'b1;
                  change_d = credit_q;
                  credit_d = '0;
               end
            end else if (bus.vend_req) begin
               rej_d = bus.coin_valid;
               if (bus.price <= credit_q) begin
                  ok_d     = 1'b1;
                  credit_d = credit_q - bus.price;
                  cnt_d    = '0;
                  state_d  = DISPENSE;
               end else begin
                  deny_d = 1'b1;
               end
            end else if (bus.coin_valid) begin
               if (bus.coin != '0 && sum <= MAX_W) begin
                  acc_d    = 1'b1;
                  credit_d = sum[CREDIT_W-1:0];
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         DISPENSE: begin
            rej_d  = bus.coin_valid;
            deny_d = bus.vend_req;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (AUTO_CHANGE == 1 && credit_q != '0) begin
                  state_d  = RETURN;
                  cv_d     = 1'b1;
                  change_d = credit_q;
                  credit_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RETURN: begin
            rej_d   = bus.coin_valid;
            deny_d  = bus.vend_req;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         credit_q <= '0;
         cnt_q    <= '0;
         acc_q    <= 1'b0;
         rej_q    <= 1'b0;
         ok_q     <= 1'b0;
         deny_q   <= 1'b0;
         cv_q     <= 1'b0;
         change_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         rej_q    <= rej_d;
         ok_q     <= ok_d;
         deny_q   <= deny_d;
         cv_q     <= cv_d;
         change_q <= change_d;
      end
   end

   assign bus.credit       = credit_q;
   assign bus.coin_accept  = acc_q;
   assign bus.coin_reject  = rej_q;
   assign bus.vend_ok      = ok_q;
   assign bus.vend_deny    = deny_q;
   assign bus.change_valid = cv_q;
   assign bus.change       = change_q;
   assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_credit_accumulator.sv
// Directed-vector bench for credit_accumulator with default parameters.
// Each row: inputs applied before an edge, registered outputs expected after it.
module tb_credit_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   credit_accumulator_if #(.COIN_W(4), .CREDIT_W(8)) bus ();

   credit_accumulator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       cv;
      logic [3:0] coin;
      logic       vr;
      logic [7:0] price;
      logic       cn;
      logic [7:0] e_credit;
      logic       e_acc;
      logic       e_rej;
      logic       e_ok;
      logic       e_deny;
      logic       e_chv;
      logic [7:0] e_change;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [21:0] pack_out(logic [7:0] c, logic a, logic r,
      logic o, logic d, logic v, logic [7:0] ch, logic b);
      return {c, a, r, o, d, v, ch, b};
   endfunction

   function automatic logic [21:0] dut_out();
      return pack_out(bus.credit, bus.coin_accept, bus.coin_reject,
         bus.vend_ok, bus.vend_deny, bus.change_valid, bus.change, bus.busy);
   endfunction

   task automatic drive(logic r, logic cv, logic [3:0] coin, logic vr,
      logic [7:0] price, logic cn);
      @(negedge clk);
      rst            = r;
      bus.coin_valid = cv;
      bus.coin       = coin;
      bus.vend_req   = vr;
      bus.price      = price;
      bus.cancel     = cn;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [21:0] act, logic [21:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(logic r, logic cv, logic [3:0] coin, logic vr,
      logic [7:0] price, logic cn, logic [7:0] ec, logic ea, logic er,
      logic eo, logic ed, logic ev, logic [7:0] ech, logic eb);
      vec_t v;
      v = '{r, cv, coin, vr, price, cn, ec, ea, er, eo, ed, ev, ech, eb};
      tbl.push_back(v);
   endtask

   initial begin
      logic seen;
      bus.coin_valid = 1'b0;
      bus.coin       = '0;
      bus.vend_req   = 1'b0;
      bus.price      = '0;
      bus.cancel     = 1'b0;

      //  rst cv coin vr price cn | credit acc rej ok deny chv change busy
      add(1, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1,  5, 0,  0, 0,   5, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1, 10, 0,  0, 0,  15, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  9, 0,  0, 0,  24, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  0, 0,  0, 0,  24, 0, 1, 0, 0, 0,  0, 0);
      add(0, 1, 15, 0,  0, 0,  39, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  6, 0,  0, 0,  45, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  6, 0,  0, 0,  45, 0, 1, 0, 0, 0,  0, 0);
      add(0, 1,  5, 0,  0, 0,  50, 1, 0, 0, 0, 0,  0, 0);
      add(0, 0,  0, 0,  0, 1,   0, 0, 0, 0, 0, 1, 50, 1);
      add(0, 1,  3, 0,  0, 0,   0, 0, 1, 0, 0, 0,  0, 0);
      add(0, 0,  0, 0,  0, 1,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1, 15, 0,  0, 0,  15, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1, 15, 0,  0, 0,  30, 1, 0, 0, 0, 0,  0, 0);
      add(0, 0,  0, 1, 25, 0,   5, 0, 0, 1, 0, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   5, 0, 0, 0, 0, 0,  0, 1);
      add(0, 1,  4, 1,  1, 1,   5, 0, 1, 0, 1, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 1,  5, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1, 10, 0,  0, 0,  10, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  3, 1, 12, 0,  10, 0, 1, 0, 1, 0,  0, 0);
      add(0, 1, 10, 0,  0, 0,  20, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  4, 1,  5, 1,   0, 0, 1, 0, 1, 1, 20, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1, 15, 0,  0, 0,  15, 1, 0, 0, 0, 0,  0, 0);
      add(0, 1,  5, 0,  0, 0,  20, 1, 0, 0, 0, 0,  0, 0);
      add(0, 0,  0, 1, 20, 0,   0, 0, 0, 1, 0, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1,  7, 0,  0, 0,   7, 1, 0, 0, 0, 0,  0, 0);
      add(1, 1,  7, 1,  1, 1,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 1, 10, 0,  0, 0,  10, 1, 0, 0, 0, 0,  0, 0);
      add(0, 0,  0, 1,  4, 0,   6, 0, 0, 1, 0, 0,  0, 1);
      add(0, 0,  0, 0,  0, 0,   6, 0, 0, 0, 0, 0,  0, 1);
      add(1, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);
      add(0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].cv, tbl[i].coin, tbl[i].vr,
            tbl[i].price, tbl[i].cn);
         check($sformatf("row%0d", i), dut_out(),
            pack_out(tbl[i].e_credit, tbl[i].e_acc, tbl[i].e_rej,
               tbl[i].e_ok, tbl[i].e_deny, tbl[i].e_chv,
               tbl[i].e_change, tbl[i].e_busy));
      end

      // Vend then wait a bounded time for the automatic change
      drive(0, 1, 9, 0, 0, 0);
      check("seq_coin9", dut_out(), pack_out(9, 1, 0, 0, 0, 0, 0, 0));
      drive(0, 0, 0, 1, 2, 0);
      check("seq_vend2", dut_out(), pack_out(7, 0, 0, 1, 0, 0, 0, 1));
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         drive(0, 0, 0, 0, 0, 0);
         seen = bus.change_valid;
      end
      if (seen) begin
         check("seq_change7", dut_out(), pack_out(0, 0, 0, 0, 0, 1, 7, 1));
      end else begin
         checks++;
         errors++;
         $display("FAIL seq_change_timeout actual=none required=change_valid");
      end
      drive(0, 0, 0, 0, 0, 0);
      check("seq_idle", dut_out(), pack_out(0, 0, 0, 0, 0, 0, 0, 0));

      // Reset while in RETURN clears everything
      drive(0, 1, 8, 0, 0, 0);
      check("seq_coin8", dut_out(), pack_out(8, 1, 0, 0, 0, 0, 0, 0));
      drive(0, 0, 0, 0, 0, 1);
      check("seq_cancel8", dut_out(), pack_out(0, 0, 0, 0, 0, 1, 8, 1));
      drive(1, 1, 3, 1, 1, 0);
      check("seq_rst_ret", dut_out(), pack_out(0, 0, 0, 0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/credit_accumulator.md
CREDIT_ACCUMULATOR -- requirements
Module: credit_accumulator

Interface
REQ-001 Parameter COIN_W, default 4, coin value width in cents-units.
REQ-002 Parameter CREDIT_W, default 8, credit/price/change width.
REQ-003 Parameter MAX_CREDIT, default 50, credit ceiling; SHALL satisfy 0 < MAX_CREDIT <= 2^CREDIT_W-1.
REQ-004 Parameter DISPENSE_CYCLES, default 3, cycles spent in DISPENSE, >= 1.
REQ-005 Parameter AUTO_CHANGE, default 1, 1 = return leftover credit automatically after a vend.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 coin_valid  in  1  coin present this cycle; coin  in  COIN_W  coin value.
REQ-009 vend_req  in  1  purchase request; price  in  CREDIT_W  item price, sampled with vend_req.
REQ-010 cancel  in  1  refund request.
REQ-011 credit  out  CREDIT_W  current accumulated credit (registered).
REQ-012 coin_accept, coin_reject  out  1 each  one-cycle coin outcome pulses.
REQ-013 vend_ok, vend_deny  out  1 each  one-cycle vend outcome pulses.
REQ-014 change_valid  out  1  one-cycle pulse; change  out  CREDIT_W  refund amount, valid only with change_valid, else 0.
REQ-015 busy  out  1  high whenever state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DISPENSE, RETURN; all outputs registered; every pulse appears the cycle after the sampling edge and lasts one cycle.
REQ-017 IDLE input priority SHALL be cancel > vend_req > coin_valid; at most one action per cycle.
REQ-018 IDLE, cancel, credit > 0: next state RETURN; cancel with credit == 0: no action, no pulses.
REQ-019 IDLE, vend_req, price <= credit: credit <= credit - price, vend_ok pulse, next state DISPENSE.
REQ-020 IDLE, vend_req, price > credit: vend_deny pulse, credit unchanged, stay IDLE.
REQ-021 IDLE, coin_valid, coin != 0, credit + coin <= MAX_CREDIT (sum computed in CREDIT_W+1 bits, no wrap): credit <= credit + coin, coin_accept pulse.
REQ-022 coin_valid with coin == 0, sum > MAX_CREDIT, state != IDLE, or losing to cancel/vend_req: coin_reject pulse, credit unchanged.
REQ-023 vend_req losing to cancel, or asserted in DISPENSE/RETURN: vend_deny pulse; cancel outside IDLE SHALL be ignored.
REQ-024 DISPENSE SHALL last exactly DISPENSE_CYCLES cycles; then RETURN if AUTO_CHANGE == 1 and credit > 0, else IDLE.
REQ-025 RETURN lasts one cycle: change_valid = 1, change = credit, credit <= 0, next state IDLE.
REQ-026 credit SHALL never exceed MAX_CREDIT nor underflow.

Reset
REQ-027 rst SHALL force state IDLE, credit 0, all pulses/change 0, busy 0, DISPENSE counter 0, at the next edge, overriding any concurrent input.
REQ-028 rst mid-DISPENSE or mid-RETURN SHALL abort with no vend_ok/change_valid emitted afterward; credit is lost (0).

Verification (defaults)
REQ-029 Coins 5,10,9 in consecutive cycles -> three coin_accept pulses, credit 5,15,24.
REQ-030 Credit 45, coin 6 -> coin_reject, credit stays 45; coin 5 -> accept, credit 50.
REQ-031 Credit 30, vend_req price 25 -> vend_ok, credit 5, busy 3 cycles, then change_valid with change 5, credit 0, IDLE.
REQ-032 Credit 10, vend_req price 12 -> vend_deny, credit 10; same cycle coin 3 -> coin_reject.
REQ-033 Credit 20, cancel + vend_req + coin 4 together -> change_valid change 20, vend_deny, coin_reject, credit 0.
REQ-034 rst asserted in second DISPENSE cycle -> next cycle credit 0, busy 0, no change_valid.
